uart_rx_cfg: RTL and testbench



---
 rtl/uart_rx_cfg.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver: configurable width, parity and stop bits, with a
// 2-of-3 majority vote per bit and a valid/ready holding register for errors.
//   state    | meaning
//   IDLE     | line idle, waiting for a low level
//   START    | validating the start bit (high vote = glitch)
//   DATA     | shifting in data bits, LSB first
//   PARITY   | checking the parity bit
//   STOP     | voting stop bits; frame completes at the last vote
//   BRK_WAIT | break seen, waiting for the line to return high
module uart_rx_cfg #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 break_detect,
  output logic                 overrun
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);
  localparam logic [SW-1:0] SMP_MAX  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SMP_A    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SMP_B    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SMP_C    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_meta;
  logic                   r_rxs;
  logic [TW-1:0]          r_tick_cnt;
  logic [SW-1:0]          r_smp_cnt;
  logic                   r_s0;
  logic                   r_s1;
  logic [DATA_BITS-1:0]   r_shift;
  logic [BW-1:0]          r_bit_cnt;
  logic                   r_stop_idx;
  logic                   r_all_zero;
  logic                   r_par_pend;
  logic                   r_frm_pend;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_brk;
  logic                   r_ovr;

  logic w_run;
  logic w_tick;
  logic w_vote_en;
  logic w_wrap;
  logic w_vote;
  logic w_start;
  logic w_done;
  logic w_brk;
  logic w_par_exp;
  logic w_load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_rxs  <= 1'b1;
    end else begin
      r_meta <= rx;
      r_rxs  <= r_meta;
    end
  end

  assign w_run     = (r_state == START) || (r_state == DATA) ||
                     (r_state == PARITY) || (r_state == STOP);
  assign w_tick    = w_run && (r_tick_cnt == TICK_MAX);
  assign w_vote_en = w_tick && (r_smp_cnt == SMP_C);
  assign w_wrap    = w_tick && (r_smp_cnt == SMP_MAX);
  // third sample is the live synchronised level at the resolving tick
  assign w_vote    = (r_s0 & r_s1) | (r_s0 & r_rxs) | (r_s1 & r_rxs);
  assign w_par_exp = (PARITY_MODE == 1) ? ^r_shift : ~^r_shift;
  assign w_load    = w_done && (!r_valid || rx_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_brk       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rxs) begin
          w_start     = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_vote_en && w_vote) w_state_nxt = IDLE;
        else if (w_wrap)         w_state_nxt = DATA;
      end
      DATA: begin
        if (w_wrap && (r_bit_cnt == BIT_LAST))
          w_state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
      end
      PARITY: begin
        if (w_wrap) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_vote_en) begin
          if (!r_stop_idx && r_all_zero && !w_vote) begin
            w_brk       = 1'b1;
            w_state_nxt = BRK_WAIT;
          end else if (r_stop_idx == STOP_LAST) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      BRK_WAIT: begin
        if (r_rxs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
      r_smp_cnt  <= '0;
    end else if (w_start || !w_run) begin
      r_tick_cnt <= '0;
      r_smp_cnt  <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
      r_smp_cnt  <= (r_smp_cnt == SMP_MAX) ? '0 : r_smp_cnt + 1'b1;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else if (w_tick) begin
      if (r_smp_cnt == SMP_A) r_s0 <= r_rxs;
      if (r_smp_cnt == SMP_B) r_s1 <= r_rxs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_idx <= 1'b0;
      r_all_zero <= 1'b1;
      r_par_pend <= 1'b0;
      r_frm_pend <= 1'b0;
    end else if (w_start) begin
      r_bit_cnt  <= '0;
      r_stop_idx <= 1'b0;
      r_all_zero <= 1'b1;
      r_par_pend <= 1'b0;
      r_frm_pend <= 1'b0;
    end else begin
      if (r_state == DATA && w_vote_en) begin
        r_shift    <= {w_vote, r_shift[DATA_BITS-1:1]};
        r_bit_cnt  <= r_bit_cnt + 1'b1;
        r_all_zero <= r_all_zero & ~w_vote;
      end
      if (r_state == PARITY && w_vote_en) begin
        r_par_pend <= (w_vote != w_par_exp);
        r_all_zero <= r_all_zero & ~w_vote;
      end
      if (r_state == STOP) begin
        if (w_vote_en && !w_vote) r_frm_pend <= 1'b1;
        if (w_wrap)               r_stop_idx <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_brk   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_brk <= w_brk;
      r_ovr <= w_done && r_valid && !rx_ready;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        r_perr  <= (PARITY_MODE != 0) && r_par_pend;
        r_ferr  <= r_frm_pend || !w_vote;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
        r_perr  <= 1'b0;
        r_ferr  <= 1'b0;
      end
    end
  end

  assign data_out      = r_data;
  assign rx_valid      = r_valid;
  assign parity_error  = r_perr;
  assign framing_error = r_ferr;
  assign break_detect  = r_brk;
  assign overrun       = r_ovr;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 8E1, 8N2) on a
// 1.6 MHz clock at 10 kbaud, so one bit lasts 160 clocks.
module tb_uart_rx_cfg;

  localparam int BIT_CLKS = 160;

  logic clk = 1'b0;
  logic reset;
  logic rx_a, rx_b, rx_c;
  logic rdy_a, rdy_b, rdy_c;
  logic [7:0] dout_a, dout_b, dout_c;
  logic val_a, val_b, val_c;
  logic perr_a, perr_b, perr_c;
  logic ferr_a, ferr_b, ferr_c;
  logic brk_a, brk_b, brk_c;
  logic ovr_a, ovr_b, ovr_c;

  int total = 0;
  int bad   = 0;
  int brk_cnt = 0;
  int ovr_cnt = 0;
  int snap;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .DATA_BITS(8),
                .PARITY_MODE(0), .STOP_BITS(1), .OVERSAMPLE(16)) dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .data_out(dout_a), .rx_valid(val_a),
    .rx_ready(rdy_a), .parity_error(perr_a), .framing_error(ferr_a),
    .break_detect(brk_a), .overrun(ovr_a));

  uart_rx_cfg #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .DATA_BITS(8),
                .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(16)) dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .data_out(dout_b), .rx_valid(val_b),
    .rx_ready(rdy_b), .parity_error(perr_b), .framing_error(ferr_b),
    .break_detect(brk_b), .overrun(ovr_b));

  uart_rx_cfg #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .DATA_BITS(8),
                .PARITY_MODE(0), .STOP_BITS(2), .OVERSAMPLE(16)) dut_c (
    .clk(clk), .reset(reset), .rx(rx_c), .data_out(dout_c), .rx_valid(val_c),
    .rx_ready(rdy_c), .parity_error(perr_c), .framing_error(ferr_c),
    .break_detect(brk_c), .overrun(ovr_c));

  // pulse monitors on instance A: count high cycles, so one pulse of one clock = 1
  always @(negedge clk) begin
    if (brk_a) brk_cnt++;
    if (ovr_a) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int idx, input logic v);
    case (idx)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // start, 8 data LSB first, optional parity, stops (stops[0] first), then idle high
  task automatic send(input int idx, input logic [7:0] d, input bit has_par,
                      input logic pbit, input int nstop, input logic [1:0] stops);
    set_rx(idx, 1'b0); hold(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      set_rx(idx, d[i]); hold(BIT_CLKS);
    end
    if (has_par) begin
      set_rx(idx, pbit); hold(BIT_CLKS);
    end
    for (int i = 0; i < nstop; i++) begin
      set_rx(idx, stops[i]); hold(BIT_CLKS);
    end
    set_rx(idx, 1'b1);
  endtask

  task automatic consume(input int idx);
    case (idx)
      0: rdy_a = 1'b1;
      1: rdy_b = 1'b1;
      default: rdy_c = 1'b1;
    endcase
    hold(1);
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    hold(4);
    check("rst_data",  {24'd0, dout_a}, 32'h0);
    check("rst_valid", {31'd0, val_a},  32'h0);
    check("rst_perr",  {31'd0, perr_b}, 32'h0);
    check("rst_ferr",  {31'd0, ferr_c}, 32'h0);
    check("rst_brk",   {31'd0, brk_a},  32'h0);
    check("rst_ovr",   {31'd0, ovr_a},  32'h0);
    reset = 1'b1;
    hold(BIT_CLKS);

    // 8N1 receive, then consume
    send(0, 8'hA5, 1'b0, 1'b0, 1, 2'b11);
    check("8n1_valid", {31'd0, val_a},  32'h1);
    check("8n1_data",  {24'd0, dout_a}, 32'hA5);
    check("8n1_perr",  {31'd0, perr_a}, 32'h0);
    check("8n1_ferr",  {31'd0, ferr_a}, 32'h0);
    consume(0);
    check("8n1_consumed", {31'd0, val_a}, 32'h0);
    hold(BIT_CLKS);

    // 8E1: 0x03 has even popcount, so correct parity bit is 0
    send(1, 8'h03, 1'b1, 1'b1, 1, 2'b11);
    check("8e1_bad_valid", {31'd0, val_b},  32'h1);
    check("8e1_bad_data",  {24'd0, dout_b}, 32'h03);
    check("8e1_bad_perr",  {31'd0, perr_b}, 32'h1);
    consume(1);
    check("8e1_perr_clear", {31'd0, perr_b}, 32'h0);
    hold(BIT_CLKS);
    send(1, 8'h03, 1'b1, 1'b0, 1, 2'b11);
    check("8e1_ok_valid", {31'd0, val_b},  32'h1);
    check("8e1_ok_data",  {24'd0, dout_b}, 32'h03);
    check("8e1_ok_perr",  {31'd0, perr_b}, 32'h0);
    consume(1);

    // glitch rejection then clean frame
    set_rx(0, 1'b0); hold(30); set_rx(0, 1'b1);
    hold(2 * BIT_CLKS);
    check("glitch_no_valid", {31'd0, val_a}, 32'h0);
    send(0, 8'h5A, 1'b0, 1'b0, 1, 2'b11);
    check("glitch_after_valid", {31'd0, val_a},  32'h1);
    check("glitch_after_data",  {24'd0, dout_a}, 32'h5A);
    consume(0);
    hold(BIT_CLKS);

    // 8N2 with second stop bit low
    send(2, 8'h55, 1'b0, 1'b0, 2, 2'b01);
    check("8n2_valid", {31'd0, val_c},  32'h1);
    check("8n2_data",  {24'd0, dout_c}, 32'h55);
    check("8n2_ferr",  {31'd0, ferr_c}, 32'h1);
    hold(2 * BIT_CLKS);
    check("8n2_no_extra_ovr", {31'd0, ovr_c}, 32'h0);
    consume(2);
    check("8n2_ferr_clear", {31'd0, ferr_c}, 32'h0);

    // break then recovery
    snap = brk_cnt;
    set_rx(0, 1'b0); hold(12 * BIT_CLKS); set_rx(0, 1'b1);
    check("brk_pulses",   brk_cnt - snap,    32'd1);
    check("brk_no_valid", {31'd0, val_a},    32'h0);
    check("brk_no_ferr",  {31'd0, ferr_a},   32'h0);
    hold(2 * BIT_CLKS);
    send(0, 8'h3C, 1'b0, 1'b0, 1, 2'b11);
    check("brk_rec_valid", {31'd0, val_a},  32'h1);
    check("brk_rec_data",  {24'd0, dout_a}, 32'h3C);
    check("brk_rec_ferr",  {31'd0, ferr_a}, 32'h0);
    consume(0);
    hold(BIT_CLKS);

    // overrun: two frames without consuming
    snap = ovr_cnt;
    send(0, 8'h11, 1'b0, 1'b0, 1, 2'b11);
    send(0, 8'h22, 1'b0, 1'b0, 1, 2'b11);
    check("ovr_valid", {31'd0, val_a},  32'h1);
    check("ovr_data",  {24'd0, dout_a}, 32'h11);
    check("ovr_pulses", ovr_cnt - snap, 32'd1);

    // reset mid-frame clears outputs asynchronously
    set_rx(0, 1'b0); hold(400);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, val_a},  32'h0);
    check("mid_rst_data",  {24'd0, dout_a}, 32'h0);
    check("mid_rst_ferr",  {31'd0, ferr_a}, 32'h0);
    hold(5);
    set_rx(0, 1'b1);
    reset = 1'b1;
    hold(2 * BIT_CLKS);
    check("post_rst_idle", {31'd0, val_a}, 32'h0);
    send(0, 8'h7E, 1'b0, 1'b0, 1, 2'b11);
    check("post_rst_valid", {31'd0, val_a},  32'h1);
    check("post_rst_data",  {24'd0, dout_a}, 32'h7E);
    check("post_rst_ferr",  {31'd0, ferr_a}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
